pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback, and owns the only write path into the program counter register.
- Computes the next PC: sequential, taken branch, jump or hold-on-halt.
- Issues the single-cycle update strobe and load value to the PC register.
- Performs req/ready handshakes with instruction and data memory.
- Sits between the decoder/ALU flags and the PC register, register file write enable and memory ports.

Parameters:
PC_STEP, 4, increment added to PC for sequential flow (byte-addressed, 32-bit instructions).
TIMEOUT_CYCLES, 64, max wait cycles on a memory handshake (used only with optional feature).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; leaves IDLE and begins fetching at current PC
pc_cur  in  32  current PC register output
imem_ready  in  1  instruction memory returns word this cycle
dmem_ready  in  1  data memory access completes this cycle
is_branch  in  1  decoded conditional branch
branch_taken  in  1  ALU condition result, valid in EXEC
branch_offset  in  32  sign-extended byte offset, valid from DECODE
is_jump  in  1  decoded unconditional jump
jump_target  in  32  absolute target, valid from DECODE
is_mem  in  1  load or store
is_load  in  1  load (ignored if is_mem=0)
is_halt  in  1  halt instruction
imem_req  out  1  fetch request, held until imem_ready
ir_load  out  1  latch instruction register (1 cycle)
dmem_req  out  1  data access request, held until dmem_ready
reg_we  out  1  register file write enable (1 cycle)
update_pc  out  1  PC register load strobe (1 cycle)
pc_next  out  32  value loaded into PC when update_pc=1
halted  out  1  sequencer in HALT
busy  out  1  state != IDLE and != HALT
error  out  1  memory timeout (optional feature only; else tied 0)

Behaviour:
- Reset: state=IDLE; all outputs 0, pc_next=0; reset wins over every other input in any state, aborting any pending handshake with no PC update.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, UPDATE, HALT.
- IDLE: start=1 -> FETCH next cycle.
- FETCH:
  - imem_req=1 for every cycle in FETCH.
  - imem_ready=1 -> ir_load=1 same cycle, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - is_halt=1 -> HALT with no PC update.
  - Otherwise -> EXEC.
- EXEC: register pc_next by priority:
  - jump: jump_target;
  - else branch & branch_taken: pc_cur+PC_STEP+branch_offset;
  - else: pc_cur+PC_STEP.
  - 32-bit modulo arithmetic, wrap without flag.
  - Then go to MEM if is_mem, else WB.
- MEM:
  - dmem_req=1 for every cycle in MEM.
  - dmem_ready=1 -> go to WB if is_load, else UPDATE.
- WB:
  - reg_we=1 for exactly one cycle, except for branch, jump and store.
  - Then go to UPDATE.
- UPDATE: update_pc=1 for exactly one cycle with stable pc_next, then go to FETCH.
- Latency, no memory waits:
  - ALU op: 6 cycles FETCH->FETCH.
  - Load: 7 cycles.
  - Store and branch: 6 cycles.
- HALT:
  - halted=1, held until reset; start ignored.
  - pc_cur is left pointing at the halt instruction.
- start outside IDLE: ignored.
- Flag inputs are sampled only in the states listed above; changes at other times have no effect.
- update_pc is never asserted in the same cycle as reg_we or dmem_req.

Optional Feature:
Macro PC_SEQ_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each waiting cycle.
  - When it reaches TIMEOUT_CYCLES without ready: error=1 (sticky until reset), go to HALT, no PC update.
- Undefined: no counter; waits are unbounded; error tied 0.

Decomposition:
- Shared package pc_seq_pkg holds:
  - state enum typedef;
  - PC_STEP default;
  - next-PC source encoding (SEQ, BRANCH, JUMP) used by the debugger/trace.
- Sub-module next_pc_calc: purely combinational priority select plus adders, instantiated once in EXEC.
- FSM and optional timeout counter stay in pc_sequencer.

Test Plan:
- Reset in WB mid-load -> next cycle state=IDLE, reg_we=0, update_pc=0, no PC change.
- pc_cur=0x100, ALU op, imem_ready after 3 waits -> update_pc one cycle with pc_next=0x104, reg_we one cycle earlier.
- pc_cur=0x200, branch taken, offset=-16 -> pc_next=0x1F4; same with branch_taken=0 -> 0x204; reg_we never 1.
- pc_cur=0xFFFFFFFC, ALU op -> pc_next=0x00000000 (wrap); jump with jump_target=0x40 plus branch_taken=1 -> 0x40 (jump priority).
- Store with dmem_ready after 2 waits -> dmem_req high 3 cycles, no reg_we, update_pc pc_next=pc_cur+4; load -> reg_we then update_pc.
- Halt opcode -> halted=1, busy=0, start pulses ignored. With PC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, imem_ready held 0 -> error=1 after 8 wait cycles, HALT entered.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM state encoding, default PC step,
// and the next-PC source encoding also used by the debugger/trace.
package pc_seq_pkg;

  localparam int unsigned PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_UPDATE,
    ST_HALT
  } seq_state_e;

  typedef enum logic [1:0] {
    PC_SRC_SEQ,
    PC_SRC_BRANCH,
    PC_SRC_JUMP
  } pc_src_e;

  // Jump beats a taken branch; anything else falls through sequentially.
  function automatic pc_src_e pc_src_sel(input logic is_jump, input logic is_branch,
                                         input logic branch_taken);
    if (is_jump)
      return PC_SRC_JUMP;
    else if (is_branch && branch_taken)
      return PC_SRC_BRANCH;
    else
      return PC_SRC_SEQ;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select: jump target, taken-branch target or
// sequential PC. All adds are 32-bit modulo and wrap silently.
module next_pc_calc
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
) (
  input  logic [31:0] pc_cur,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc_next
);

  logic [31:0] pc_seq;
  pc_src_e     src;

  assign pc_seq = pc_cur + PC_STEP;

  // Priority select of the next-PC source.
  always_comb begin
    src = pc_src_sel(is_jump, is_branch, branch_taken);
    case (src)
      PC_SRC_JUMP:   pc_next = jump_target;
      PC_SRC_BRANCH: pc_next = pc_seq + branch_offset;
      default:       pc_next = pc_seq;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer; sole writer of the PC register.
// Optional memory-handshake timeout is enabled by defining PC_SEQ_TIMEOUT_EN
// (adds the TIMEOUT_CYCLES parameter and drives error).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_FETCH  | imem_req held until imem_ready, then latch IR
// ST_DECODE | halt check
// ST_EXEC   | next PC registered; pick MEM or WB
// ST_MEM    | dmem_req held until dmem_ready
// ST_WB     | one-cycle reg_we unless branch/jump/store
// ST_UPDATE | one-cycle update_pc with registered pc_next
// ST_HALT   | halted until reset; start ignored
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_STEP = PC_STEP_DEFAULT
`ifdef PC_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        is_branch,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        is_jump,
  input  logic [31:0] jump_target,
  input  logic        is_mem,
  input  logic        is_load,
  input  logic        is_halt,
  output logic        imem_req,
  output logic        ir_load,
  output logic        dmem_req,
  output logic        reg_we,
  output logic        update_pc,
  output logic [31:0] pc_next,
  output logic        halted,
  output logic        busy,
  output logic        error
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_next_q;
  logic [31:0] pc_calc;
  logic        timeout;

  next_pc_calc #(.PC_STEP(PC_STEP)) u_next_pc_calc (
    .pc_cur        (pc_cur),
    .is_branch     (is_branch),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .is_jump       (is_jump),
    .jump_target   (jump_target),
    .pc_next       (pc_calc)
  );

`ifdef PC_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              error_q;
  logic              waiting;

  assign waiting = ((state_q == ST_FETCH) && !imem_ready) ||
                   ((state_q == ST_MEM)   && !dmem_ready);
  assign timeout = waiting && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign error   = error_q;

  // Wait counter is zero outside a stalled handshake, so every FETCH/MEM
  // entry starts from zero; error is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      if (timeout)
        error_q <= 1'b1;
      if (waiting)
        wait_q <= wait_q + 1'b1;
      else
        wait_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  // State register and next-PC capture in EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_next_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EXEC)
        pc_next_q <= pc_calc;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    dmem_req  = 1'b0;
    reg_we    = 1'b0;
    update_pc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_HALT;
        end
      end
      ST_DECODE: begin
        state_d = is_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        state_d = is_mem ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready)
          state_d = is_load ? ST_WB : ST_UPDATE;
        else if (timeout)
          state_d = ST_HALT;
      end
      ST_WB: begin
        reg_we  = !(is_branch || is_jump || (is_mem && !is_load));
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        update_pc = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pc_next = pc_next_q;
  assign halted  = (state_q == ST_HALT);
  assign busy    = (state_q != ST_IDLE) && (state_q != ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: table of instructions run back to back, with a
// scoreboard of expected PC updates checked by a monitor, plus hand-written
// sequences for halt, reset-in-WB and (when enabled) handshake timeout.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] pc_cur;
  logic        imem_ready, dmem_ready;
  logic        is_branch, branch_taken;
  logic [31:0] branch_offset;
  logic        is_jump;
  logic [31:0] jump_target;
  logic        is_mem, is_load, is_halt;
  logic        imem_req, ir_load, dmem_req, reg_we, update_pc;
  logic [31:0] pc_next;
  logic        halted, busy, error;

  always #5 clk = ~clk;

`ifdef PC_SEQ_TIMEOUT_EN
  pc_sequencer #(.TIMEOUT_CYCLES(8)) dut (
`else
  pc_sequencer dut (
`endif
    .clk(clk), .reset(reset), .start(start), .pc_cur(pc_cur),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .is_branch(is_branch), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .is_jump(is_jump),
    .jump_target(jump_target), .is_mem(is_mem), .is_load(is_load),
    .is_halt(is_halt), .imem_req(imem_req), .ir_load(ir_load),
    .dmem_req(dmem_req), .reg_we(reg_we), .update_pc(update_pc),
    .pc_next(pc_next), .halted(halted), .busy(busy), .error(error)
  );

  typedef struct {
    logic [31:0] pc_next;
    logic        we;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic        br, tk, jmp, mem, ld, hlt;
    logic [31:0] off, tgt;
    int          iwait, dwait;
    logic [31:0] exp_pc;
    logic        exp_we;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   we_cnt = 0;
  logic prev_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: every update_pc pops one expected PC and checks the reg_we history.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (reset) begin
      we_cnt  = 0;
      prev_we = 1'b0;
    end else begin
      if (update_pc) begin
        chk("upd_overlap", {30'd0, reg_we, dmem_req}, 32'd0);
        if (sb.size() == 0) begin
          bound_fail("spurious_update_pc");
        end else begin
          e = sb.pop_front();
          chk("pc_next", pc_next, e.pc_next);
          chk("reg_we_count", we_cnt, {31'd0, e.we});
          chk("reg_we_prev_cycle", {31'd0, prev_we}, {31'd0, e.we});
        end
        we_cnt = 0;
      end
      if (reg_we) we_cnt++;
      prev_we = reg_we;
    end
  end

  function automatic vec_t mk(input logic [31:0] pc, input logic br, input logic tk,
                              input logic jmp, input logic mem, input logic ld,
                              input logic hlt, input logic [31:0] off,
                              input logic [31:0] tgt, input int iw, input int dw,
                              input logic [31:0] epc, input logic ewe, input int lat);
    vec_t v;
    v.pc = pc; v.br = br; v.tk = tk; v.jmp = jmp; v.mem = mem; v.ld = ld;
    v.hlt = hlt; v.off = off; v.tgt = tgt; v.iwait = iw; v.dwait = dw;
    v.exp_pc = epc; v.exp_we = ewe; v.exp_lat = lat;
    return v;
  endfunction

  task automatic set_flags(input vec_t v);
    pc_cur = v.pc; is_branch = v.br; branch_taken = v.tk; is_jump = v.jmp;
    is_mem = v.mem; is_load = v.ld; is_halt = v.hlt;
    branch_offset = v.off; jump_target = v.tgt;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Run one instruction; returns at negedge+2 of its UPDATE (or HALT) cycle.
  task automatic run(input vec_t v, input int idx);
    int   cyc, iw, dw, n_dmem, n_ir;
    bit   done;
    exp_t e;
    cyc = 0; iw = 0; dw = 0; n_dmem = 0; n_ir = 0; done = 0;
    set_flags(v);
    if (!v.hlt) begin
      e.pc_next = v.exp_pc;
      e.we = v.exp_we;
      sb.push_back(e);
    end
    if (!busy && !halted) begin
      @(negedge clk);
      start = 1'b1;
    end
    while (!done) begin
      @(negedge clk);
      start = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      if (imem_req) begin
        if (iw == v.iwait) imem_ready = 1'b1;
        else iw++;
      end
      if (dmem_req) begin
        n_dmem++;
        if (dw == v.dwait) dmem_ready = 1'b1;
        else dw++;
      end
      cyc++;
      #2;
      if (ir_load) n_ir++;
      if (v.hlt ? halted : update_pc) done = 1;
      else if (cyc >= 100) begin
        bound_fail($sformatf("vec%0d_done", idx));
        done = 1;
      end
    end
    chk($sformatf("vec%0d_ir_load", idx), n_ir, 1);
    chk($sformatf("vec%0d_dmem_cycles", idx), n_dmem, v.mem ? v.dwait + 1 : 0);
    if (!v.hlt) chk($sformatf("vec%0d_latency", idx), cyc + 1, v.exp_lat);
  endtask

  vec_t vt[10];

  initial begin
    int n;
    bit got;
    reset = 1'b1; start = 1'b0; pc_cur = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    is_branch = 1'b0; branch_taken = 1'b0; branch_offset = '0; is_jump = 1'b0;
    jump_target = '0; is_mem = 1'b0; is_load = 1'b0; is_halt = 1'b0;

    //           pc            br tk jp mm ld ht off           tgt         iw dw exp_pc        we lat
    vt[0] = mk(32'h0000_0100, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      3, 0, 32'h0000_0104, 1, 9);
    vt[1] = mk(32'h0000_0200, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,     0, 0, 32'h0000_01F4, 0, 6);
    vt[2] = mk(32'h0000_0200, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,     0, 0, 32'h0000_0204, 0, 6);
    vt[3] = mk(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0, 32'h0000_0000, 1, 6);
    vt[4] = mk(32'h0000_0300, 1, 1, 1, 0, 0, 0, 32'h0000_0100, 32'h40,    0, 0, 32'h0000_0040, 0, 6);
    vt[5] = mk(32'h0000_0400, 0, 0, 0, 1, 0, 0, 32'h0,        32'h0,      0, 2, 32'h0000_0404, 0, 8);
    vt[6] = mk(32'h0000_0500, 0, 0, 0, 1, 1, 0, 32'h0,        32'h0,      0, 0, 32'h0000_0504, 1, 7);
    vt[7] = mk(32'h0000_1000, 0, 0, 0, 1, 1, 0, 32'h0,        32'h0,      1, 1, 32'h0000_1004, 1, 9);
    vt[8] = mk(32'hFFFF_FFF0, 1, 1, 0, 0, 0, 0, 32'h0000_0020, 32'h0,     0, 0, 32'h0000_0014, 0, 6);
    vt[9] = mk(32'h0000_2000, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,      0, 0, 32'h0,         0, 0);

    do_reset();
    #2;
    chk("reset_outputs", {24'd0, imem_req, ir_load, dmem_req, reg_we, update_pc, halted, busy, error}, 32'd0);
    chk("reset_pc_next", pc_next, 32'd0);

    for (int i = 0; i < 10; i++) run(vt[i], i);

    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("halt_start_ignored", {29'd0, halted, busy, imem_req}, 32'h4);
    chk("halt_sb_empty", sb.size(), 0);

    // Reset while a load sits in WB: no PC update may follow.
    do_reset();
    set_flags(mk(32'h600, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk); start = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      start = 1'b0; imem_ready = imem_req; dmem_ready = dmem_req;
      #2;
      if (reg_we) got = 1;
    end
    if (!got) bound_fail("wb_reach");
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_wb_outputs", {28'd0, busy, reg_we, update_pc, halted}, 32'd0);
    chk("rst_wb_pc_next", pc_next, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    chk("rst_wb_idle", {30'd0, busy, update_pc}, 32'd0);

`ifdef PC_SEQ_TIMEOUT_EN
    do_reset();
    @(negedge clk); start = 1'b1;
    n = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      start = 1'b0; imem_ready = 1'b0;
      #2;
      if (imem_req) n++;
      if (halted) got = 1;
    end
    if (!got) bound_fail("timeout_halt");
    chk("timeout_wait_cycles", n, 8);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
`else
    n = 0;
    chk("error_tied_low", {31'd0, error}, 32'd0);
`endif

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
